flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Sits directly downstream of the combinational ALU.
- Registers the ALU's carry/shift-out, zero and greater flags, and feeds them back to the ALU as SC_IN, ZERO_IN and GREATER_IN.
- Resolves conditional branches against those flags and produces a registered redirect target plus a multi-cycle flush to the fetch/decode front end.
- Detects a same-cycle flag-write/branch hazard, stalls one cycle and re-evaluates against the updated flags.

Parameters:
PC_W, 10, program counter width in bits
FLUSH_CYCLES, 2, cycles FLUSH stays high after a taken branch (1..7)
CNT_W, 16, width of the taken-branch statistics counter

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
SC_OUT  input  1  ALU shift/carry out
ZERO  input  1  ALU zero flag
GREATER  input  1  ALU greater flag
FLAG_WE  input  1  latch ZERO and GREATER this cycle
SC_WE  input  1  latch SC_OUT this cycle
BR_VALID  input  1  branch instruction present this cycle
BR_COND  input  3  branch condition code
BR_OFFSET  input  8  signed branch displacement
PC_IN  input  PC_W  PC of the branch instruction
SC_IN  output  1  registered carry flag, to ALU
ZERO_IN  output  1  registered zero flag, to ALU
GREATER_IN  output  1  registered greater flag, to ALU
STALL  output  1  combinational hazard stall to front end
TAKEN  output  1  registered one-cycle redirect strobe
TARGET  output  PC_W  redirect PC, valid when TAKEN=1
FLUSH  output  1  registered squash of younger instructions
TAKEN_COUNT  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (synchronous, active-high):
  - SC_IN, ZERO_IN, GREATER_IN, TAKEN, FLUSH = 0.
  - TARGET = 0, TAKEN_COUNT = 0, state = IDLE, flush counter = 0.
  - Reset asserted mid-HOLD or mid-REDIRECT aborts the operation and wins over every other input.
- Flag register:
  - FLAG_WE=1 loads ZERO/GREATER at the edge; SC_WE=1 loads SC_OUT. The two enables are independent.
  - Flags update only in IDLE or HOLD; writes are ignored in REDIRECT (the writer has been squashed).
- Condition codes, evaluated on the registered flags:
  - 0 always; 1 eq (ZERO_IN); 2 ne (!ZERO_IN); 3 gt (GREATER_IN).
  - 4 le (!GREATER_IN); 5 cs (SC_IN); 6 cc (!SC_IN); 7 reserved, never taken.
- Target arithmetic: TARGET = PC_IN + sign-extended BR_OFFSET, modulo 2^PC_W. Wrap-around is silent, with no error.
- State machine:
  - IDLE, no hazard: BR_VALID=1 with FLAG_WE=0 and SC_WE=0 evaluates the condition this cycle.
    - Taken: go to REDIRECT; TAKEN=1 and TARGET loaded in the next cycle.
    - Not taken: stay in IDLE with no output activity.
  - IDLE, hazard: BR_VALID=1 with FLAG_WE=1 or SC_WE=1.
    - STALL=1 combinationally this cycle only.
    - Latch BR_COND, BR_OFFSET and PC_IN, and go to HOLD. Flags update normally at the same edge.
  - HOLD (exactly one cycle):
    - Evaluate the latched branch against the now-updated flags.
    - Taken goes to REDIRECT; not taken goes to IDLE.
    - BR_VALID is ignored; the front end supplies a bubble. Flag writes are accepted.
  - REDIRECT:
    - TAKEN=1 only in its first cycle.
    - FLUSH=1 for exactly FLUSH_CYCLES cycles, starting with the TAKEN cycle; then return to IDLE.
    - BR_VALID, FLAG_WE and SC_WE are ignored throughout.
    - TARGET holds its value until the next taken branch.
- Latency: a branch without a hazard has TAKEN one cycle after BR_VALID; with a hazard, two cycles.
- TAKEN_COUNT: increments by 1 in each cycle TAKEN=1 and saturates at all ones (no wrap).
- STALL is never asserted outside IDLE.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0; ZERO=1 with FLAG_WE=1 → ZERO_IN=1 the next cycle and GREATER_IN stays 0.
- ZERO_IN=1; BR_VALID with BR_COND=1, PC_IN=0x010, BR_OFFSET=0xFC → next cycle TAKEN=1, TARGET=0x00C; FLUSH high 2 cycles; TAKEN_COUNT=1.
- BR_VALID with BR_COND=3 and FLAG_WE=1 in the same cycle, GREATER=1, GREATER_IN previously 0 → STALL=1 that cycle only; TAKEN=1 two cycles after BR_VALID.
- PC_IN=0x3FE, BR_OFFSET=0x05, BR_COND=0 → TARGET=0x003 (wrap); BR_COND=7 under any flags → TAKEN never asserted.
- During REDIRECT, drive FLAG_WE=1 with ZERO=1 and BR_VALID=1 → ZERO_IN unchanged, no second TAKEN; Reset in the second flush cycle → FLUSH=0 and state IDLE on the next cycle.
- CNT_W=2: five taken branches → TAKEN_COUNT reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Sits behind the combinational ALU. It holds the ALU flags (carry/shift-out,
//   zero, greater) and feeds them back to the ALU. It also resolves conditional
//   branches against those registered flags.
//
//   Normal branch : BR_VALID in IDLE with no flag write in the same cycle.
//                   TAKEN/TARGET appear one cycle later.
//   Hazard branch : BR_VALID in IDLE while FLAG_WE/SC_WE is also set.
//                   STALL is raised for that cycle and the branch is parked.
//                   It is then re-evaluated in HOLD against the fresh flags,
//                   so TAKEN appears two cycles after BR_VALID.
//   Redirect      : TAKEN is pulsed for one cycle. FLUSH stays high for
//                   FLUSH_CYCLES cycles starting with the TAKEN cycle.
//                   Flag writes and branches are dropped while redirecting,
//                   because they come from squashed instructions.
//
// Ports
//   CLK, Reset         clock, synchronous active-high reset
//   SC_OUT/ZERO/GREATER  ALU flag results
//   FLAG_WE / SC_WE    load ZERO+GREATER / SC_OUT at the next edge
//   BR_VALID, BR_COND, BR_OFFSET, PC_IN   branch request
//   SC_IN/ZERO_IN/GREATER_IN  registered flags back to the ALU
//   STALL              combinational hazard stall (IDLE only)
//   TAKEN, TARGET      registered redirect strobe and PC
//   FLUSH              registered squash of younger instructions
//   TAKEN_COUNT        saturating count of taken branches
module flag_branch_unit #(
  parameter int PC_W         = 10,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             SC_OUT,
  input  logic             ZERO,
  input  logic             GREATER,
  input  logic             FLAG_WE,
  input  logic             SC_WE,
  input  logic             BR_VALID,
  input  logic [2:0]       BR_COND,
  input  logic [7:0]       BR_OFFSET,
  input  logic [PC_W-1:0]  PC_IN,
  output logic             SC_IN,
  output logic             ZERO_IN,
  output logic             GREATER_IN,
  output logic             STALL,
  output logic             TAKEN,
  output logic [PC_W-1:0]  TARGET,
  output logic             FLUSH,
  output logic [CNT_W-1:0] TAKEN_COUNT
);

  typedef enum logic [1:0] {IDLE, HOLD, REDIRECT} state_t;

  // A branch is reduced to its condition and its already-computed target.
  // Parking the target instead of PC+offset keeps the HOLD path short.
  typedef struct packed {
    logic [2:0]      cond;
    logic [PC_W-1:0] target;
  } br_req_t;

  // The counter holds the number of FLUSH cycles still owed after the current one.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] flush_cnt;
  br_req_t    held_req;
  br_req_t    in_req;
  br_req_t    cur_req;
  logic       hazard;
  logic       fire;
  logic       take;

  function automatic logic cond_met(input logic [2:0] c, input logic sc,
                                    input logic z, input logic g);
    logic r;
    r = 1'b0;
    case (c)
      3'd0:    r = 1'b1;
      3'd1:    r = z;
      3'd2:    r = !z;
      3'd3:    r = g;
      3'd4:    r = !g;
      3'd5:    r = sc;
      3'd6:    r = !sc;
      default: r = 1'b0;   // code 7 is reserved and never taken
    endcase
    return r;
  endfunction

  always_comb begin
    in_req.cond   = BR_COND;
    // The target wraps modulo 2^PC_W.
    in_req.target = PC_IN + PC_W'($signed(BR_OFFSET));
  end

  // A flag write in the same cycle as a branch would change the condition
  // after it was evaluated. The branch is therefore deferred by one cycle.
  assign hazard  = (state == IDLE) && BR_VALID && (FLAG_WE || SC_WE);
  assign STALL   = hazard;
  assign cur_req = (state == HOLD) ? held_req : in_req;
  assign fire    = ((state == IDLE) && BR_VALID && !hazard) || (state == HOLD);
  assign take    = fire && cond_met(cur_req.cond, SC_IN, ZERO_IN, GREATER_IN);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      held_req    <= '0;
      SC_IN       <= 1'b0;
      ZERO_IN     <= 1'b0;
      GREATER_IN  <= 1'b0;
      TAKEN       <= 1'b0;
      TARGET      <= '0;
      FLUSH       <= 1'b0;
      TAKEN_COUNT <= '0;
    end else begin
      // Writes seen during REDIRECT come from squashed instructions.
      if (state != REDIRECT) begin
        if (FLAG_WE) begin
          ZERO_IN    <= ZERO;
          GREATER_IN <= GREATER;
        end
        if (SC_WE) SC_IN <= SC_OUT;
      end

      TAKEN <= 1'b0;

      case (state)
        IDLE: begin
          if (hazard) begin
            held_req <= in_req;
            state    <= HOLD;
          end
        end
        HOLD: state <= IDLE;   // overridden below when the branch is taken
        REDIRECT: begin
          if (flush_cnt == '0) begin
            FLUSH <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // take can only be set in IDLE or HOLD.
      if (take) begin
        state     <= REDIRECT;
        TAKEN     <= 1'b1;
        TARGET    <= cur_req.target;
        FLUSH     <= 1'b1;
        flush_cnt <= FLUSH_LAST;
        if (TAKEN_COUNT != '1) TAKEN_COUNT <= TAKEN_COUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;
  logic       CLK, Reset, SC_OUT, ZERO, GREATER, FLAG_WE, SC_WE, BR_VALID;
  logic [2:0] BR_COND;
  logic [7:0] BR_OFFSET;
  logic [9:0] PC_IN;
  logic       SC_IN, ZERO_IN, GREATER_IN, STALL, TAKEN, FLUSH;
  logic [9:0] TARGET;
  logic [15:0] TAKEN_COUNT;
  logic       sc_in2, zero_in2, greater_in2, stall2, taken2, flush2;
  logic [9:0] target2;
  logic [1:0] taken_count2;

  int vectors = 0;
  int miscompares = 0;

  flag_branch_unit #(.PC_W(10), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .CLK(CLK), .Reset(Reset), .SC_OUT(SC_OUT), .ZERO(ZERO), .GREATER(GREATER),
    .FLAG_WE(FLAG_WE), .SC_WE(SC_WE), .BR_VALID(BR_VALID), .BR_COND(BR_COND),
    .BR_OFFSET(BR_OFFSET), .PC_IN(PC_IN), .SC_IN(SC_IN), .ZERO_IN(ZERO_IN),
    .GREATER_IN(GREATER_IN), .STALL(STALL), .TAKEN(TAKEN), .TARGET(TARGET),
    .FLUSH(FLUSH), .TAKEN_COUNT(TAKEN_COUNT));

  // Narrow-counter copy that shares the stimulus and checks saturation.
  flag_branch_unit #(.PC_W(10), .FLUSH_CYCLES(2), .CNT_W(2)) u_dut_c2 (
    .CLK(CLK), .Reset(Reset), .SC_OUT(SC_OUT), .ZERO(ZERO), .GREATER(GREATER),
    .FLAG_WE(FLAG_WE), .SC_WE(SC_WE), .BR_VALID(BR_VALID), .BR_COND(BR_COND),
    .BR_OFFSET(BR_OFFSET), .PC_IN(PC_IN), .SC_IN(sc_in2), .ZERO_IN(zero_in2),
    .GREATER_IN(greater_in2), .STALL(stall2), .TAKEN(taken2), .TARGET(target2),
    .FLUSH(flush2), .TAKEN_COUNT(taken_count2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    FLAG_WE = 0; SC_WE = 0; BR_VALID = 0;
  endtask

  // Sweep every condition code against fixed flags. exp_tbl[c] gives the
  // hand-derived taken result for code c.
  task automatic cond_sweep(input logic [7:0] exp_tbl, input string tag);
    for (int c = 0; c < 8; c++) begin
      BR_VALID = 1; BR_COND = 3'(c); PC_IN = 10'h040; BR_OFFSET = 8'h08;
      tick;
      BR_VALID = 0;
      chk($sformatf("%s_c%0d", tag, c), {31'd0, TAKEN}, {31'd0, exp_tbl[c]});
      if (exp_tbl[c]) begin
        chk($sformatf("%s_tgt%0d", tag, c), {22'd0, TARGET}, 32'h048);
        tick; tick;
      end
    end
  endtask

  initial begin
    Reset = 1; SC_OUT = 0; ZERO = 0; GREATER = 0; idle_inputs();
    BR_COND = 0; BR_OFFSET = 0; PC_IN = 0;
    tick; tick;
    Reset = 0;
    tick;
    chk("rst_sc", {31'd0, SC_IN}, 0);
    chk("rst_zero", {31'd0, ZERO_IN}, 0);
    chk("rst_gt", {31'd0, GREATER_IN}, 0);
    chk("rst_taken", {31'd0, TAKEN}, 0);
    chk("rst_flush", {31'd0, FLUSH}, 0);
    chk("rst_target", {22'd0, TARGET}, 0);
    chk("rst_count", {16'd0, TAKEN_COUNT}, 0);
    chk("rst_stall", {31'd0, STALL}, 0);

    // Flag write, then check that the two enables are independent.
    ZERO = 1; FLAG_WE = 1;
    tick;
    FLAG_WE = 0;
    chk("fw_zero", {31'd0, ZERO_IN}, 1);
    chk("fw_gt", {31'd0, GREATER_IN}, 0);
    ZERO = 0; SC_OUT = 1; SC_WE = 1;
    tick;
    SC_WE = 0;
    chk("scw_sc", {31'd0, SC_IN}, 1);
    chk("scw_zero_kept", {31'd0, ZERO_IN}, 1);

    // beq taken with a negative offset: 0x010 + (-4) = 0x00C.
    BR_VALID = 1; BR_COND = 3'd1; PC_IN = 10'h010; BR_OFFSET = 8'hFC;
    #1 chk("beq_nostall", {31'd0, STALL}, 0);
    tick;
    BR_VALID = 0;
    chk("beq_taken", {31'd0, TAKEN}, 1);
    chk("beq_target", {22'd0, TARGET}, 32'h00C);
    chk("beq_flush1", {31'd0, FLUSH}, 1);
    tick;
    chk("beq_taken_pulse", {31'd0, TAKEN}, 0);
    chk("beq_flush2", {31'd0, FLUSH}, 1);
    chk("beq_count", {16'd0, TAKEN_COUNT}, 1);
    tick;
    chk("beq_flush_end", {31'd0, FLUSH}, 0);

    // bgt with GREATER_IN=0 is not taken.
    BR_VALID = 1; BR_COND = 3'd3;
    tick;
    BR_VALID = 0;
    chk("bgt_nt_taken", {31'd0, TAKEN}, 0);
    chk("bgt_nt_flush", {31'd0, FLUSH}, 0);

    // Hazard: bgt together with a write of GREATER=1. The branch is resolved
    // against the new flag. The bubble in HOLD carries a branch to be ignored.
    BR_VALID = 1; BR_COND = 3'd3; FLAG_WE = 1; GREATER = 1; ZERO = 1;
    PC_IN = 10'h100; BR_OFFSET = 8'h10;
    #1 chk("hz_stall", {31'd0, STALL}, 1);
    tick;
    FLAG_WE = 0; BR_COND = 3'd0; PC_IN = 10'h200;
    #1 chk("hz_hold_stall", {31'd0, STALL}, 0);
    chk("hz_hold_taken", {31'd0, TAKEN}, 0);
    chk("hz_gt_updated", {31'd0, GREATER_IN}, 1);
    tick;
    BR_VALID = 0;
    chk("hz_taken", {31'd0, TAKEN}, 1);
    chk("hz_target", {22'd0, TARGET}, 32'h110);
    tick;
    chk("hz_count", {16'd0, TAKEN_COUNT}, 2);
    chk("hz_single_taken", {31'd0, TAKEN}, 0);
    tick;

    // Hazard re-evaluation makes a branch not taken: beq while ZERO drops to 0.
    BR_VALID = 1; BR_COND = 3'd1; FLAG_WE = 1; ZERO = 0;
    #1 chk("hz2_stall", {31'd0, STALL}, 1);
    tick;
    idle_inputs();
    chk("hz2_zero", {31'd0, ZERO_IN}, 0);
    tick;
    chk("hz2_not_taken", {31'd0, TAKEN}, 0);
    chk("hz2_no_flush", {31'd0, FLUSH}, 0);

    // Wrapping target: 0x3FE + 5 = 0x003 (mod 1024).
    BR_VALID = 1; BR_COND = 3'd0; PC_IN = 10'h3FE; BR_OFFSET = 8'h05;
    tick;
    chk("wrap_taken", {31'd0, TAKEN}, 1);
    chk("wrap_target", {22'd0, TARGET}, 32'h003);
    // Flag writes and a branch during REDIRECT must be ignored.
    BR_VALID = 1; FLAG_WE = 1; ZERO = 1; SC_WE = 1; SC_OUT = 0;
    #1 chk("redir_stall", {31'd0, STALL}, 0);
    tick;
    chk("redir_zero_kept", {31'd0, ZERO_IN}, 0);
    chk("redir_sc_kept", {31'd0, SC_IN}, 1);
    chk("redir_no_taken", {31'd0, TAKEN}, 0);
    chk("redir_flush2", {31'd0, FLUSH}, 1);
    chk("redir_count", {16'd0, TAKEN_COUNT}, 3);
    // Reset in the second flush cycle.
    Reset = 1;
    tick;
    Reset = 0; idle_inputs();
    chk("midrst_flush", {31'd0, FLUSH}, 0);
    chk("midrst_taken", {31'd0, TAKEN}, 0);
    chk("midrst_target", {22'd0, TARGET}, 0);
    chk("midrst_count", {16'd0, TAKEN_COUNT}, 0);
    chk("midrst_sc", {31'd0, SC_IN}, 0);

    // Five taken branches. The first one also shows the state is back in IDLE
    // because TAKEN follows after a single cycle.
    begin
      logic [1:0] exp_c2 [5];
      exp_c2[0] = 1; exp_c2[1] = 2; exp_c2[2] = 3; exp_c2[3] = 3; exp_c2[4] = 3;
      for (int i = 0; i < 5; i++) begin
        BR_VALID = 1; BR_COND = 3'd0; PC_IN = 10'h020; BR_OFFSET = 8'h01;
        tick;
        BR_VALID = 0;
        chk($sformatf("sat_taken%0d", i), {31'd0, taken2}, 1);
        tick;
        chk($sformatf("sat_cnt%0d", i), {30'd0, taken_count2}, {30'd0, exp_c2[i]});
        tick;
      end
      chk("wide_cnt5", {16'd0, TAKEN_COUNT}, 5);
      chk("sat_target", {22'd0, target2}, 32'h021);
    end

    // All flags set: codes 0,1,3,5 are taken.
    FLAG_WE = 1; SC_WE = 1; ZERO = 1; GREATER = 1; SC_OUT = 1;
    tick;
    idle_inputs();
    cond_sweep(8'b0010_1011, "ones");
    // All flags clear: codes 0,2,4,6 are taken.
    FLAG_WE = 1; SC_WE = 1; ZERO = 0; GREATER = 0; SC_OUT = 0;
    tick;
    idle_inputs();
    cond_sweep(8'b0101_0101, "zeros");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
